seven_seg: RTL and testbench

//  Registered hex-to-7-segment decoder for one digit with a pushbutton-controlled hold (freeze) mode.
//  - Drives a single 7-segment digit plus its decimal point from a 4-bit value (encoder/counter output).
//  - key toggles hold; while hold=1 the displayed digit is frozen and the dot is lit.

---
 rtl/seven_seg.sv | 118 +++++++++++
 tb/tb_seven_seg.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seven_seg.sv
// Registered hex-to-7-segment decoder for one digit with a pushbutton hold (freeze) mode.
// A key press toggles hold; while hold is set the digit is frozen and the decimal point is lit.
// Optional key debounce is compiled in with SEVENSEG_DEBOUNCE_EN; without it the synchronized
// key level feeds the edge detector directly and DEBOUNCE_CYCLES has no effect.
// Outputs are registered; SEG_ACTIVE_LOW only flips their polarity on the way out.
module seven_seg #(
  parameter bit          SEG_ACTIVE_LOW  = 1'b0,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  input  logic [3:0] enc,
  output logic [6:0] seg_d,
  output logic       dot
);

  logic       key_s1;
  logic       key_s2;
  logic       key_level;
  logic       key_level_d;
  logic       key_rise;
  logic       hold;
  logic [6:0] seg_q;
  logic [6:0] seg_next;

  // Segment pattern {g,f,e,d,c,b,a} for every hex value; no blank code.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Two-flop synchronizer for the asynchronous pushbutton.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_s1 <= 1'b0;
      key_s2 <= 1'b0;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
    end
  end

`ifdef SEVENSEG_DEBOUNCE_EN
  logic [15:0] deb_cnt;
  logic        deb_level;

  // The debounced level follows the synchronized key only after it has differed from it for
  // DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_cnt   <= 16'd0;
      deb_level <= 1'b0;
    end else if (key_s2 == deb_level) begin
      deb_cnt <= 16'd0;
    end else if (deb_cnt >= DEBOUNCE_CYCLES - 16'd1) begin
      deb_cnt   <= 16'd0;
      deb_level <= key_s2;
    end else begin
      deb_cnt <= deb_cnt + 16'd1;
    end
  end

  assign key_level = deb_level;
`else
  logic unused_debounce_cycles;
  assign unused_debounce_cycles = ^DEBOUNCE_CYCLES;
  assign key_level = key_s2;
`endif

  // Previous key level, so a press yields exactly one rise and a held key never repeats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) key_level_d <= 1'b0;
    else      key_level_d <= key_level;
  end

  assign key_rise = key_level & ~key_level_d;

  // Hold flips on each press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          hold <= 1'b0;
    else if (key_rise) hold <= ~hold;
  end

  // Next digit: track enc while not holding (hold value before the edge), else keep the frozen one.
  always_comb begin
    seg_next = seg_q;
    if (!hold) seg_next = decode(enc);
  end

  // Registered segment pattern, polarity-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) seg_q <= 7'h00;
    else      seg_q <= seg_next;
  end

  assign seg_d = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign dot   = hold ^ SEG_ACTIVE_LOW;

endmodule

// File: tb/tb_seven_seg.sv
// Randomized bench for seven_seg (default build, no debounce). Two instances share inputs:
// one active-high, one active-low. A behavioural model predicts the display from the list of
// key samples taken since reset and from the hex table.
module tb_seven_seg;

  logic       clk;
  logic       rst;
  logic       key;
  logic [3:0] enc;
  logic [6:0] seg_d;
  logic       dot;
  logic [6:0] seg_inv;
  logic       dot_inv;

  int n_total;
  int n_bad;

  // Model state
  logic [6:0] seg_tbl [16];
  logic       samp_q [$];
  logic       hold_m;
  logic [6:0] seg_m;

  seven_seg #(.SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .key(key), .enc(enc), .seg_d(seg_d), .dot(dot)
  );

  seven_seg #(.SEG_ACTIVE_LOW(1'b1)) dut_inv (
    .clk(clk), .rst(rst), .key(key), .enc(enc), .seg_d(seg_inv), .dot(dot_inv)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    samp_q.delete();
    // Key reads as released for the edges preceding reset release.
    for (int i = 0; i < 3; i++) samp_q.push_back(1'b0);
    hold_m = 1'b0;
    seg_m  = 7'h00;
  endtask

  // A press toggles hold on the third edge that samples the key high (first high after a low).
  task automatic model_edge(input logic k, input logic [3:0] e);
    int n;
    logic press;
    samp_q.push_back(k);
    n = samp_q.size();
    press = samp_q[n-3] && !samp_q[n-4];
    if (!hold_m) seg_m = seg_tbl[e];
    if (press) hold_m = !hold_m;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_seg"},     {1'b0, seg_d},   {1'b0, seg_m});
    check({tag, "_dot"},     {7'b0, dot},     {7'b0, hold_m});
    check({tag, "_seg_inv"}, {1'b0, seg_inv}, {1'b0, ~seg_m});
    check({tag, "_dot_inv"}, {7'b0, dot_inv}, {7'b0, ~hold_m});
  endtask

  // Driver: apply inputs away from the edge, advance the model at the edge, sample just after.
  task automatic drive_cycle(input string tag, input logic k, input logic [3:0] e);
    @(negedge clk);
    key = k;
    enc = e;
    @(posedge clk);
    model_edge(k, e);
    #1;
    check_outputs(tag);
  endtask

  task automatic apply_reset(input string tag, input int cycles);
    @(negedge clk);
    rst = 1'b0;
    key = 1'b0;
    model_reset();
    #1;
    check_outputs(tag);
    repeat (cycles) @(posedge clk);
    #1;
    check_outputs(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic       k;
    logic [3:0] e;
    int         run;
    n_total = 0;
    n_bad   = 0;
    seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    rst = 1'b0;
    key = 1'b0;
    enc = 4'd5;
    model_reset();

    // Reset with enc=5, then one clock shows 6D.
    apply_reset("reset", 3);
    drive_cycle("first", 1'b0, 4'd5);
    check("first_6d", {1'b0, seg_d}, 8'h6D);

    // Counting 0..F with wrap, key released.
    for (int i = 0; i < 34; i++) drive_cycle("count", 1'b0, 4'(i));

    // Press for 4 clocks while counting, stay frozen 20 clocks.
    e = 4'd3;
    for (int i = 0; i < 4; i++) begin drive_cycle("press1", 1'b1, e); e = e + 4'd1; end
    for (int i = 0; i < 20; i++) begin drive_cycle("frozen", 1'b0, e); e = e + 4'd1; end
    check("frozen_dot", {7'b0, dot}, 8'h01);

    // Second press releases the freeze.
    for (int i = 0; i < 4; i++) begin drive_cycle("press2", 1'b1, e); e = e + 4'd1; end
    for (int i = 0; i < 6; i++) begin drive_cycle("unfrozen", 1'b0, e); e = e + 4'd1; end
    check("unfrozen_dot", {7'b0, dot}, 8'h00);

    // Key held 100 clocks: a single toggle.
    for (int i = 0; i < 100; i++) drive_cycle("held", 1'b1, 4'($urandom_range(0, 15)));
    check("held_dot", {7'b0, dot}, 8'h01);
    for (int i = 0; i < 5; i++) drive_cycle("held_rel", 1'b0, 4'($urandom_range(0, 15)));

    // Reset while holding.
    apply_reset("reset_hold", 2);
    drive_cycle("after_rst", 1'b0, 4'd8);
    check("after_rst_inv", {1'b0, seg_inv}, 8'h00);

    // Random enc with random-length key runs, including single-cycle presses.
    k = 1'b0;
    for (int r = 0; r < 60; r++) begin
      k = ~k;
      run = $urandom_range(1, 8);
      for (int i = 0; i < run; i++) drive_cycle("rand", k, 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 5; i++) drive_cycle("rand_tail", 1'b0, 4'($urandom_range(0, 15)));

    // Final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
